// File: rtl/mme_axi_rd_arbiter.sv
// Round-robin AXI AR arbiter for the MME A/B fetch paths, with RID-based R routing and per-requester outstanding limits.
// AR: request to m_arvalid in one cycle, one handshake per two cycles; R: combinational, m_rready follows the selected requester.
module mme_axi_rd_arbiter #(
  parameter int ID_W      = 4,
  parameter int AW        = 32,
  parameter int DW        = 128,
  parameter int MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_arvalid,
  input  logic [AW-1:0]   s0_araddr,
  input  logic [3:0]      s0_arlen,
  output logic            s0_arready,
  output logic            s0_rvalid,
  output logic [DW-1:0]   s0_rdata,
  output logic            s0_rlast,
  output logic [1:0]      s0_rresp,
  input  logic            s0_rready,
  input  logic            s1_arvalid,
  input  logic [AW-1:0]   s1_araddr,
  input  logic [3:0]      s1_arlen,
  output logic            s1_arready,
  output logic            s1_rvalid,
  output logic [DW-1:0]   s1_rdata,
  output logic            s1_rlast,
  output logic [1:0]      s1_rresp,
  input  logic            s1_rready,
  output logic            m_arvalid,
  output logic [ID_W-1:0] m_arid,
  output logic [AW-1:0]   m_araddr,
  output logic [3:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  input  logic            m_arready,
  input  logic            m_rvalid,
  input  logic [ID_W-1:0] m_rid,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rlast,
  input  logic [1:0]      m_rresp,
  output logic            m_rready
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_OUTST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt, last;
  logic [CW-1:0] cnt0, cnt1;
  logic          elig0, elig1, ar_hs, sel, r_done;
  logic          inc0, inc1, dec0, dec1;
  logic          unused_rid_hi;

  assign elig0 = s0_arvalid && (cnt0 < LIMIT);
  assign elig1 = s1_arvalid && (cnt1 < LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      if (ar_hs) last <= gnt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    m_arvalid  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    ar_hs      = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          gnt_nxt   = !last;
          state_nxt = GRANT;
        end else if (elig0) begin
          gnt_nxt   = 1'b0;
          state_nxt = GRANT;
        end else if (elig1) begin
          gnt_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        m_arvalid  = 1'b1;
        s0_arready = !gnt && m_arready;
        s1_arready = gnt && m_arready;
        ar_hs      = m_arready;
        if (m_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_arid    = {{(ID_W-1){1'b0}}, gnt};
  assign m_araddr  = gnt ? s1_araddr : s0_araddr;
  assign m_arlen   = gnt ? s1_arlen : s0_arlen;
  assign m_arsize  = 3'($clog2(DW / 8));
  assign m_arburst = 2'b01;

  // R path is pure steering; upper RID bits are never issued so they are ignored.
  assign sel           = m_rid[0];
  assign unused_rid_hi = ^m_rid[ID_W-1:1];
  assign s0_rvalid     = m_rvalid && !sel;
  assign s1_rvalid     = m_rvalid && sel;
  assign s0_rdata      = m_rdata;
  assign s1_rdata      = m_rdata;
  assign s0_rlast      = m_rlast;
  assign s1_rlast      = m_rlast;
  assign s0_rresp      = m_rresp;
  assign s1_rresp      = m_rresp;
  assign m_rready      = sel ? s1_rready : s0_rready;

  assign r_done = m_rvalid && m_rready && m_rlast;
  assign inc0   = ar_hs && !gnt;
  assign inc1   = ar_hs && gnt;
  assign dec0   = r_done && !sel;
  assign dec1   = r_done && sel;

  // A decrement at zero (stray beat, e.g. after reset) saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (inc0 && !dec0)                      cnt0 <= cnt0 + 1'b1;
      else if (dec0 && !inc0 && cnt0 != '0)   cnt0 <= cnt0 - 1'b1;
      if (inc1 && !dec1)                      cnt1 <= cnt1 + 1'b1;
      else if (dec1 && !inc1 && cnt1 != '0)   cnt1 <= cnt1 - 1'b1;
    end
  end

endmodule

// File: tb/tb_mme_axi_rd_arbiter.sv
// Directed bench for mme_axi_rd_arbiter: AR arbitration, limits, R routing and reset.
module tb_mme_axi_rd_arbiter;
  localparam int ID_W = 4, AW = 32, DW = 128, MAX_OUTST = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic            s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [AW-1:0]   s0_araddr, s1_araddr;
  logic [3:0]      s0_arlen, s1_arlen;
  logic            s0_rvalid, s1_rvalid, s0_rlast, s1_rlast, s0_rready, s1_rready;
  logic [DW-1:0]   s0_rdata, s1_rdata;
  logic [1:0]      s0_rresp, s1_rresp;
  logic            m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [ID_W-1:0] m_arid, m_rid;
  logic [AW-1:0]   m_araddr;
  logic [3:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst, m_rresp;
  logic [DW-1:0]   m_rdata;

  int tests = 0;
  int fails = 0;

  mme_axi_rd_arbiter #(.ID_W(ID_W), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
    .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rresp(m_rresp),
    .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rlast = 0; m_rresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    clear_inputs();
    s0_rready = 1; s1_rready = 0;
    step(); step();
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid: got %b want 0", m_arvalid); end
    tests++; if ({s0_arready, s1_arready} !== 2'b00) begin fails++; $display("FAIL reset_arready: got %b want 00", {s0_arready, s1_arready}); end
    tests++; if (dut.cnt0 !== 3'd0 || dut.cnt1 !== 3'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", dut.cnt0, dut.cnt1); end
    tests++; if ({s0_rvalid, s1_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", {s0_rvalid, s1_rvalid}); end
    tests++; if (m_rready !== 1'b1) begin fails++; $display("FAIL reset_rready_follow_s0: got %b want 1", m_rready); end
    tests++; if (m_arsize !== 3'd4 || m_arburst !== 2'b01) begin fails++; $display("FAIL const_size_burst: got %0d/%b want 4/01", m_arsize, m_arburst); end
    rst = 0;
    settle();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_data;
    s0_arvalid = 1; s0_araddr = 32'h1000; s0_arlen = 4'd3; m_arready = 1;
    settle();
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL single_no_early_arvalid: got %b want 0", m_arvalid); end
    step();
    tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0 || m_arlen !== 4'd3 || m_araddr !== 32'h1000) begin
      fails++; $display("FAIL single_ar: got v=%b id=%0d len=%0d addr=%h want 1/0/3/1000", m_arvalid, m_arid, m_arlen, m_araddr); end
    tests++; if ({s0_arready, s1_arready} !== 2'b10) begin fails++; $display("FAIL single_arready: got %b want 10", {s0_arready, s1_arready}); end
    step();
    s0_arvalid = 0; m_arready = 0;
    settle();
    tests++; if (dut.cnt0 !== 3'd1 || m_arvalid !== 1'b0) begin fails++; $display("FAIL single_after_hs: got cnt0=%0d v=%b want 1/0", dut.cnt0, m_arvalid); end
    s0_rready = 1; s1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_data = {32'hCAFE0000 + 32'(i), 96'h0};
      m_rvalid = 1; m_rid = 4'd0; m_rdata = exp_data; m_rlast = (i == 3); m_rresp = (i == 2) ? 2'b10 : 2'b00;
      settle();
      tests++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || s0_rdata !== exp_data || m_rready !== 1'b1) begin
        fails++; $display("FAIL single_rbeat%0d: got v0=%b v1=%b rdy=%b data=%h", i, s0_rvalid, s1_rvalid, m_rready, s0_rdata); end
      if (i == 2) begin
        tests++; if (s0_rresp !== 2'b10) begin fails++; $display("FAIL single_rresp: got %b want 10", s0_rresp); end
      end
      step();
      if (i < 3) begin
        tests++; if (dut.cnt0 !== 3'd1) begin fails++; $display("FAIL single_cnt_mid%0d: got %0d want 1", i, dut.cnt0); end
      end
    end
    m_rvalid = 0; m_rlast = 0;
    settle();
    tests++; if (dut.cnt0 !== 3'd0) begin fails++; $display("FAIL single_cnt_rlast: got %0d want 0", dut.cnt0); end
  endtask

  task automatic test_backpressure();
    s1_arvalid = 1; s1_araddr = 32'h2000; s1_arlen = 4'd7; m_arready = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd1 || m_araddr !== 32'h2000 || {s0_arready, s1_arready} !== 2'b00) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b id=%0d addr=%h rdy=%b", i, m_arvalid, m_arid, m_araddr, {s0_arready, s1_arready}); end
      step();
    end
    m_arready = 1;
    settle();
    tests++; if (s1_arready !== 1'b1 || s0_arready !== 1'b0) begin fails++; $display("FAIL bp_release: got %b want 01", {s0_arready, s1_arready}); end
    step();
    s1_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rid = 4'd1; m_rlast = 1; s0_rready = 1; s1_rready = 0;
    settle();
    tests++; if (m_rready !== 1'b0 || s0_rvalid !== 1'b0 || s1_rvalid !== 1'b1) begin
      fails++; $display("FAIL bp_rready: got rdy=%b v0=%b v1=%b want 0/0/1", m_rready, s0_rvalid, s1_rvalid); end
    step(); step();
    tests++; if (dut.cnt1 !== 3'd1) begin fails++; $display("FAIL bp_cnt_hold: got %0d want 1", dut.cnt1); end
    s1_rready = 1;
    step();
    m_rvalid = 0; m_rlast = 0;
    settle();
    tests++; if (dut.cnt1 !== 3'd0) begin fails++; $display("FAIL bp_cnt_dec: got %0d want 0", dut.cnt1); end
  endtask

  task automatic test_simultaneous();
    s0_arvalid = 1; m_arready = 1; s0_rready = 1; s1_rready = 1;
    step(); step();
    tests++; if (dut.cnt0 !== 3'd1) begin fails++; $display("FAIL sim_pre: got %0d want 1", dut.cnt0); end
    step();
    m_rvalid = 1; m_rid = 4'd0; m_rlast = 1;
    step();
    m_rvalid = 0; s0_arvalid = 0;
    settle();
    tests++; if (dut.cnt0 !== 3'd1) begin fails++; $display("FAIL sim_same_cnt: got %0d want 1", dut.cnt0); end
    s1_arvalid = 1;
    step(); step();
    s1_arvalid = 0; s0_arvalid = 1;
    step();
    m_rvalid = 1; m_rid = 4'd1; m_rlast = 1;
    step();
    m_rvalid = 0; m_rlast = 0; m_arready = 0;
    settle();
    tests++; if (dut.cnt0 !== 3'd2 || dut.cnt1 !== 3'd0) begin fails++; $display("FAIL sim_cross_cnt: got %0d/%0d want 2/0", dut.cnt0, dut.cnt1); end
    step();
    tests++; if (m_arvalid !== 1'b1 || dut.cnt0 !== 3'd2) begin fails++; $display("FAIL sim_grant_pre_rst: got v=%b cnt0=%0d want 1/2", m_arvalid, dut.cnt0); end
  endtask

  task automatic test_reset_mid();
    rst = 1; m_arready = 1;
    settle();
    tests++; if (m_arvalid !== 1'b0 || s0_arready !== 1'b0) begin fails++; $display("FAIL rstmid_ar: got v=%b rdy=%b want 0/0", m_arvalid, s0_arready); end
    tests++; if (dut.cnt0 !== 3'd0 || dut.cnt1 !== 3'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", dut.cnt0, dut.cnt1); end
    rst = 0; s0_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rid = 4'd0; m_rlast = 1; s0_rready = 1;
    settle();
    tests++; if (s0_rvalid !== 1'b1) begin fails++; $display("FAIL rstmid_route: got %b want 1", s0_rvalid); end
    step();
    m_rvalid = 0; m_rlast = 0;
    settle();
    tests++; if (dut.cnt0 !== 3'd0) begin fails++; $display("FAIL rstmid_no_wrap: got %0d want 0", dut.cnt0); end
    s0_arvalid = 1; s1_arvalid = 1;
    step();
    tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd0) begin fails++; $display("FAIL rstmid_first_tie: got v=%b id=%0d want 1/0", m_arvalid, m_arid); end
  endtask

  task automatic test_contention();
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
    settle();
    for (int i = 0; i < 8; i++) begin
      step();
      tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'(i % 2)) begin
        fails++; $display("FAIL cont_grant%0d: got v=%b id=%0d want 1/%0d", i, m_arvalid, m_arid, i % 2); end
      step();
      tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL cont_idle%0d: got %b want 0", i, m_arvalid); end
    end
    tests++; if (dut.cnt0 !== 3'd4 || dut.cnt1 !== 3'd4) begin fails++; $display("FAIL cont_cnt: got %0d/%0d want 4/4", dut.cnt0, dut.cnt1); end
    step(); step();
    tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL cont_limit: got %b want 0", m_arvalid); end
  endtask

  task automatic test_limit_release();
    s0_arvalid = 0; s1_rready = 1;
    m_rvalid = 1; m_rid = 4'd1; m_rlast = 1;
    settle();
    tests++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0) begin fails++; $display("FAIL lim_route: got %b%b want 01", s0_rvalid, s1_rvalid); end
    step();
    m_rvalid = 0; m_rlast = 0;
    settle();
    tests++; if (dut.cnt1 !== 3'd3 || m_arvalid !== 1'b0) begin fails++; $display("FAIL lim_dec: got cnt1=%0d v=%b want 3/0", dut.cnt1, m_arvalid); end
    step();
    tests++; if (m_arvalid !== 1'b1 || m_arid !== 4'd1) begin fails++; $display("FAIL lim_regrant: got v=%b id=%0d want 1/1", m_arvalid, m_arid); end
    step();
    s1_arvalid = 0;
    settle();
    tests++; if (dut.cnt1 !== 3'd4) begin fails++; $display("FAIL lim_reinc: got %0d want 4", dut.cnt1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    do_reset();
    test_contention();
    test_limit_release();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
